// File: rtl/pipe_sum_pkg.sv
// Shared sizing helpers for the pipelined reduction adder (pipe_sum_tree).
// Everything here is elaboration-time arithmetic; no hardware is described.
package pipe_sum_pkg;

  localparam int DEFAULT_ELEMENTS = 12;
  localparam int DEFAULT_IN_WIDTH = 8;

  // Number of register levels in the tree; a single lane still gets one stage.
  function automatic int num_levels(input int elements);
    return (elements <= 1) ? 1 : $clog2(elements);
  endfunction

  // Nodes held at level k: ceil(elements / 2^k). Level 0 is the raw input.
  function automatic int level_nodes(input int elements, input int k);
    return (elements + (1 << k) - 1) >> k;
  endfunction

  // Width of the last level, i.e. the lossless sum width.
  function automatic int full_width(input int in_width, input int elements);
    return in_width + num_levels(elements);
  endfunction

  // Bit offset of level k inside the flattened level chain (levels 0..k-1 below it).
  function automatic int level_offset(input int in_width, input int elements, input int k);
    int off;
    off = 0;
    for (int m = 0; m < k; m++) off += level_nodes(elements, m) * (in_width + m);
    return off;
  endfunction

endpackage

// File: rtl/pipe_sum_tree_if.sv
// Valid/ready stream bundle for pipe_sum_tree; out_sat exists only when
// PIPE_SUM_TREE_SAT_EN is defined.
interface pipe_sum_tree_if
  import pipe_sum_pkg::*;
#(
  parameter int ELEMENTS  = DEFAULT_ELEMENTS,
  parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int OUT_WIDTH = DEFAULT_IN_WIDTH + $clog2(DEFAULT_ELEMENTS)
) ();

  logic [ELEMENTS*IN_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic                         out_valid;
  logic                         out_ready;
`ifdef PIPE_SUM_TREE_SAT_EN
  logic                         out_sat;
`endif

  modport master (
    output in_data, in_valid, out_ready,
`ifdef PIPE_SUM_TREE_SAT_EN
    input  out_sat,
`endif
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
`ifdef PIPE_SUM_TREE_SAT_EN
    output out_sat,
`endif
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/pipe_sum_level.sv
// One registered level of the reduction tree: pairwise adds, with an odd
// trailing node extended by one bit and passed through unchanged.
module pipe_sum_level
  import pipe_sum_pkg::*;
#(
  parameter int NODES_IN = 2,
  parameter int W_IN     = 8,
  parameter int SIGNED   = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          adv_i,
  input  logic                                          valid_i,
  input  logic [NODES_IN*W_IN-1:0]                      data_i,
  output logic                                          valid_o,
  output logic [level_nodes(NODES_IN, 1)*(W_IN+1)-1:0] data_o
);

  localparam int NODES_OUT = level_nodes(NODES_IN, 1);
  localparam int W_OUT     = W_IN + 1;

  logic [NODES_OUT*W_OUT-1:0] data_d;
  logic [NODES_OUT*W_OUT-1:0] data_q;
  logic                       valid_q;

  for (genvar j = 0; j < NODES_OUT; j++) begin : g_node
    logic [W_IN-1:0]  a;
    logic [W_OUT-1:0] a_ext;

    assign a     = data_i[2*j*W_IN +: W_IN];
    assign a_ext = {(SIGNED != 0) && a[W_IN-1], a};

    if (2*j + 1 < NODES_IN) begin : g_pair
      logic [W_IN-1:0]  b;
      logic [W_OUT-1:0] b_ext;

      assign b     = data_i[(2*j+1)*W_IN +: W_IN];
      assign b_ext = {(SIGNED != 0) && b[W_IN-1], b};
      assign data_d[j*W_OUT +: W_OUT] = a_ext + b_ext;
    end else begin : g_pass
      assign data_d[j*W_OUT +: W_OUT] = a_ext;
    end
  end

  // NOTE: the data registers are reset too (not just valid) so that out_data
  // reads 0 after reset; they only load when an accepted valid item arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      // NOTE: non-blocking assignments keep every level sampling the
      // pre-edge value of the level below, which is what makes this a pipeline.
      valid_q <= valid_i;
      if (valid_i) data_q <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_sum_tree.sv
// Pipelined valid/ready reduction adder over ELEMENTS lanes, one register per
// adder level. Define PIPE_SUM_TREE_SAT_EN to saturate a narrow OUT_WIDTH.
module pipe_sum_tree
  import pipe_sum_pkg::*;
#(
  parameter int ELEMENTS  = DEFAULT_ELEMENTS,
  parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int SIGNED    = 1,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(ELEMENTS)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  pipe_sum_tree_if.slave bus
);

  localparam int LEVELS  = num_levels(ELEMENTS);
  localparam int FULL_W  = full_width(IN_WIDTH, ELEMENTS);
  localparam int CHAIN_W = level_offset(IN_WIDTH, ELEMENTS, LEVELS + 1);
  localparam int LAST_OF = level_offset(IN_WIDTH, ELEMENTS, LEVELS);

  // All levels flattened into one vector; level 0 is the input lanes.
  logic [CHAIN_W-1:0] chain;
  logic [LEVELS:0]    chain_v;
  logic               stall;
  logic               adv;
  logic [FULL_W-1:0]  sum_full;

  // A full output that is not being taken freezes the whole tree.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;

  assign chain[ELEMENTS*IN_WIDTH-1:0] = bus.in_data;
  assign chain_v[0]                   = bus.in_valid;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NIN    = level_nodes(ELEMENTS, k - 1);
    localparam int NOUT   = level_nodes(ELEMENTS, k);
    localparam int WIN    = IN_WIDTH + k - 1;
    localparam int OFF_I  = level_offset(IN_WIDTH, ELEMENTS, k - 1);
    localparam int OFF_O  = level_offset(IN_WIDTH, ELEMENTS, k);

    pipe_sum_level #(
      .NODES_IN (NIN),
      .W_IN     (WIN),
      .SIGNED   (SIGNED)
    ) u_level (
      .clk     (clk_in),
      .rst     (rst_in),
      .adv_i   (adv),
      .valid_i (chain_v[k-1]),
      .data_i  (chain[OFF_I +: NIN*WIN]),
      .valid_o (chain_v[k]),
      .data_o  (chain[OFF_O +: NOUT*(WIN+1)])
    );
  end

  assign sum_full      = chain[LAST_OF +: FULL_W];
  assign bus.out_valid = chain_v[LEVELS];

  if (OUT_WIDTH > FULL_W) begin : g_extend
    logic ext_bit;
    assign ext_bit      = (SIGNED != 0) && sum_full[FULL_W-1];
    assign bus.out_data = {{(OUT_WIDTH-FULL_W){ext_bit}}, sum_full};
`ifdef PIPE_SUM_TREE_SAT_EN
    assign bus.out_sat  = 1'b0;
`endif
  end else if (OUT_WIDTH == FULL_W) begin : g_exact
    assign bus.out_data = sum_full;
`ifdef PIPE_SUM_TREE_SAT_EN
    assign bus.out_sat  = 1'b0;
`endif
  end else begin : g_narrow
`ifdef PIPE_SUM_TREE_SAT_EN
    if (SIGNED != 0) begin : g_sat_signed
      // The sum fits only if every bit from the result sign upward agrees.
      logic [FULL_W-OUT_WIDTH:0] hi;
      logic                      ovf;
      assign hi  = sum_full[FULL_W-1:OUT_WIDTH-1];
      assign ovf = !((&hi) || !(|hi));
      assign bus.out_data = !ovf ? sum_full[OUT_WIDTH-1:0]
                          : sum_full[FULL_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      assign bus.out_sat  = ovf;
    end else begin : g_sat_unsigned
      logic ovf;
      assign ovf          = |sum_full[FULL_W-1:OUT_WIDTH];
      assign bus.out_data = ovf ? {OUT_WIDTH{1'b1}} : sum_full[OUT_WIDTH-1:0];
      assign bus.out_sat  = ovf;
    end
`else
    assign bus.out_data = sum_full[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_pipe_sum_tree.sv
// Directed bench for pipe_sum_tree: signed and unsigned 12x8 trees, plus an
// 8-bit saturating instance when PIPE_SUM_TREE_SAT_EN is defined.
module tb_pipe_sum_tree;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_sum_tree_if #(.ELEMENTS(12), .IN_WIDTH(8), .OUT_WIDTH(12)) bus_s ();
  pipe_sum_tree_if #(.ELEMENTS(12), .IN_WIDTH(8), .OUT_WIDTH(12)) bus_u ();

  pipe_sum_tree #(.ELEMENTS(12), .IN_WIDTH(8), .SIGNED(1), .OUT_WIDTH(12)) dut_s (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_s)
  );

  pipe_sum_tree #(.ELEMENTS(12), .IN_WIDTH(8), .SIGNED(0), .OUT_WIDTH(12)) dut_u (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_u)
  );

`ifdef PIPE_SUM_TREE_SAT_EN
  pipe_sum_tree_if #(.ELEMENTS(12), .IN_WIDTH(8), .OUT_WIDTH(8)) bus_t ();

  pipe_sum_tree #(.ELEMENTS(12), .IN_WIDTH(8), .SIGNED(1), .OUT_WIDTH(8)) dut_t (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_t)
  );
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  int          got;
  int          first_c;
  int          last_c;
  logic [95:0] d;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] fill(input logic [7:0] v);
    logic [95:0] r;
    for (int i = 0; i < 12; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Reference signed sum of 12 byte lanes, kept to the 12-bit result width.
  function automatic logic [11:0] ref_s(input logic [95:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 12; i++) s += int'($signed(v[i*8 +: 8]));
    return 12'(s);
  endfunction

  task automatic wait_out(input string tag);
    n = 1;
    while (!bus_s.out_valid && n < 12) begin
      tick();
      n++;
    end
    if (!bus_s.out_valid) chk(tag, 32'(bus_s.out_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_s.in_data = '0; bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1;
    bus_u.in_data = '0; bus_u.in_valid = 1'b0; bus_u.out_ready = 1'b1;
`ifdef PIPE_SUM_TREE_SAT_EN
    bus_t.in_data = '0; bus_t.in_valid = 1'b0; bus_t.out_ready = 1'b1;
`endif

    // Reset state.
    #12;
    chk("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus_s.out_data), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus_s.in_ready), 32'd1);

    // Lanes 1..12 -> 78 after exactly four cycles, for one cycle only.
    for (int i = 0; i < 12; i++) d[i*8 +: 8] = 8'(i + 1);
    bus_s.in_data = d; bus_s.in_valid = 1'b1;
`ifdef PIPE_SUM_TREE_SAT_EN
    bus_t.in_data = 96'd5; bus_t.in_valid = 1'b1;
`endif
    tick();
    bus_s.in_valid = 1'b0;
`ifdef PIPE_SUM_TREE_SAT_EN
    bus_t.in_valid = 1'b0;
`endif
    wait_out("seq_timeout");
    chk("seq_latency", 32'(n), 32'd4);
    chk("seq_sum", 32'(bus_s.out_data), 32'd78);
`ifdef PIPE_SUM_TREE_SAT_EN
    chk("sat_small_data", 32'(bus_t.out_data), 32'd5);
    chk("sat_small_flag", 32'(bus_t.out_sat), 32'd0);
`endif
    tick();
    chk("seq_one_shot", 32'(bus_s.out_valid), 32'd0);

    // Extremes: signed all -128, unsigned all 0xFF, saturating all 100.
    bus_s.in_data = fill(8'h80); bus_s.in_valid = 1'b1;
    bus_u.in_data = fill(8'hFF); bus_u.in_valid = 1'b1;
`ifdef PIPE_SUM_TREE_SAT_EN
    bus_t.in_data = fill(8'd100); bus_t.in_valid = 1'b1;
`endif
    tick();
    bus_s.in_valid = 1'b0;
    bus_u.in_valid = 1'b0;
`ifdef PIPE_SUM_TREE_SAT_EN
    bus_t.in_valid = 1'b0;
`endif
    wait_out("ext_timeout");
    chk("min_signed", 32'(bus_s.out_data), 32'h0A00);
    chk("max_unsigned_valid", 32'(bus_u.out_valid), 32'd1);
    chk("max_unsigned", 32'(bus_u.out_data), 32'd3060);
`ifdef PIPE_SUM_TREE_SAT_EN
    chk("sat_big_data", 32'(bus_t.out_data), 32'h7F);
    chk("sat_big_flag", 32'(bus_t.out_sat), 32'd1);
`endif
    tick();

    // Twenty back-to-back random vectors at full rate.
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 32; c++) begin
      if (c < 20) begin
        d = {$urandom, $urandom, $urandom};
        bus_s.in_data = d; bus_s.in_valid = 1'b1;
        exp_q.push_back(ref_s(d));
      end else begin
        bus_s.in_valid = 1'b0;
      end
      tick();
      if (bus_s.out_valid) begin
        got++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (exp_q.size() > 0) chk("b2b_data", 32'(bus_s.out_data), 32'(exp_q.pop_front()));
      end
    end
    chk("b2b_count", 32'(got), 32'd20);
    chk("b2b_contiguous", 32'(last_c - first_c + 1), 32'd20);
    exp_q.delete();

    // Backpressure: three vectors in flight, output held for six cycles.
    bus_s.out_ready = 1'b0;
    bus_s.in_data = fill(8'd1); bus_s.in_valid = 1'b1; exp_q.push_back(12'd12);
    tick();
    bus_s.in_data = fill(8'd2); exp_q.push_back(12'd24);
    tick();
    bus_s.in_data = fill(8'hFF); exp_q.push_back(12'hFF4);
    tick();
    bus_s.in_valid = 1'b0;
    bus_s.in_data = fill(8'h55);
    wait_out("stall_timeout");
    chk("stall_in_ready", 32'(bus_s.in_ready), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("stall_hold_valid", 32'(bus_s.out_valid), 32'd1);
      chk("stall_hold_data", 32'(bus_s.out_data), 32'd12);
    end
    bus_s.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus_s.out_valid) begin
        got++;
        if (exp_q.size() > 0) chk("stall_drain_data", 32'(bus_s.out_data), 32'(exp_q.pop_front()));
      end
      tick();
    end
    chk("stall_drain_count", 32'(got), 32'd3);

    // Asynchronous reset between edges with two vectors in flight.
    bus_s.in_data = fill(8'd3); bus_s.in_valid = 1'b1;
    tick();
    bus_s.in_data = fill(8'd4);
    tick();
    bus_s.in_valid = 1'b0;
    wait_out("areset_timeout");
    #2;
    rst = 1'b1;
    #1;
    chk("areset_valid", 32'(bus_s.out_valid), 32'd0);
    chk("areset_data", 32'(bus_s.out_data), 32'd0);
    #3;
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus_s.out_valid) got++;
    end
    chk("areset_no_stale", 32'(got), 32'd0);
    chk("areset_in_ready", 32'(bus_s.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
